// File: rtl/stopwatch_top_if.sv
// Control strobes and display outputs of the mm:ss stopwatch.
// The master drives the strobes and the slave drives the counters and status.
interface stopwatch_top_if;
    logic       start;
    logic       stop;
    logic       reset;
    logic [7:0] minutes;
    logic [5:0] seconds;
    logic [1:0] status;

    modport master (output start, stop, reset, input minutes, seconds, status);
    modport slave  (input start, stop, reset, output minutes, seconds, status);
endinterface

// File: rtl/stopwatch_top.sv
// Minutes:seconds stopwatch with a prescaler-driven one-second tick and start/pause/clear strobes.
// Optional macro STOPWATCH_SATURATE_EN: hold at MAX_MIN:59 and pause instead of wrapping to 00:00.
module stopwatch_top #(
    parameter int unsigned TICK_DIV = 1,
    parameter int unsigned MAX_MIN  = 99
) (
    input  logic           clk,
    input  logic           rst_n,
    stopwatch_top_if.slave sw
);
    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RUNNING = 2'b01,
        PAUSED  = 2'b10
    } state_e;

    state_e        state_q;
    logic [7:0]    min_q;
    logic [5:0]    sec_q;
    logic [PW-1:0] pre_q;
    logic          tick_d;
    logic          at_max_d;

    always_comb begin
        tick_d   = (state_q == RUNNING) && (pre_q == PW'(TICK_DIV - 1));
        at_max_d = (min_q == 8'(MAX_MIN)) && (sec_q == 6'd59);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            min_q   <= '0;
            sec_q   <= '0;
            pre_q   <= '0;
        end else if (sw.reset) begin
            state_q <= IDLE;
            min_q   <= '0;
            sec_q   <= '0;
            pre_q   <= '0;
        end else begin
            case (state_q)
                IDLE, PAUSED: begin
                    // stop outranks start, so a simultaneous pair leaves the state untouched
                    if (!sw.stop && sw.start) state_q <= RUNNING;
                end
                RUNNING: begin
                    if (sw.stop) begin
                        state_q <= PAUSED;
                    end else if (tick_d) begin
                        pre_q <= '0;
                        if (at_max_d) begin
`ifdef STOPWATCH_SATURATE_EN
                            state_q <= PAUSED;
`else
                            min_q <= '0;
                            sec_q <= '0;
`endif
                        end else if (sec_q == 6'd59) begin
                            sec_q <= '0;
                            min_q <= min_q + 8'd1;
                        end else begin
                            sec_q <= sec_q + 6'd1;
                        end
                    end else begin
                        pre_q <= pre_q + PW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sw.minutes = min_q;
    assign sw.seconds = sec_q;
    assign sw.status  = state_q;
endmodule

// File: tb/tb_stopwatch_top.sv
// Self-checking bench: two stopwatches (TICK_DIV=1 and 4) driven with identical strobes,
// compared every cycle against an elapsed-seconds reference model.
module tb_stopwatch_top;
    localparam int MAX_MIN = 99;
    localparam int LIMIT   = (MAX_MIN + 1) * 60;

    typedef struct {
        int state;    // 0 idle, 1 running, 2 paused
        int elapsed;  // total seconds shown
        int phase;    // cycles accumulated toward the next second
    } mdl_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;
    mdl_t m1, m4;

    always #5 clk = ~clk;

    stopwatch_top_if sw1 ();
    stopwatch_top_if sw4 ();

    stopwatch_top #(.TICK_DIV(1), .MAX_MIN(MAX_MIN)) u_div1 (.clk(clk), .rst_n(rst_n), .sw(sw1));
    stopwatch_top #(.TICK_DIV(4), .MAX_MIN(MAX_MIN)) u_div4 (.clk(clk), .rst_n(rst_n), .sw(sw4));

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    function automatic mdl_t mdl_clear();
        mdl_t r;
        r.state = 0; r.elapsed = 0; r.phase = 0;
        return r;
    endfunction

    function automatic mdl_t step(mdl_t m, bit st, bit sp, bit rs, int div);
        mdl_t n = m;
        if (rs) return mdl_clear();
        if (m.state == 1) begin
            if (sp) n.state = 2;
            else if (m.phase + 1 == div) begin
                n.phase = 0;
                if (m.elapsed == LIMIT - 1) begin
`ifdef STOPWATCH_SATURATE_EN
                    n.state = 2;
`else
                    n.elapsed = 0;
`endif
                end else n.elapsed = m.elapsed + 1;
            end else n.phase = m.phase + 1;
        end else if (!sp && st) n.state = 1;
        return n;
    endfunction

    task automatic compare_all();
        check("div1.status",  int'(sw1.status),  m1.state);
        check("div1.minutes", int'(sw1.minutes), m1.elapsed / 60);
        check("div1.seconds", int'(sw1.seconds), m1.elapsed % 60);
        check("div4.status",  int'(sw4.status),  m4.state);
        check("div4.minutes", int'(sw4.minutes), m4.elapsed / 60);
        check("div4.seconds", int'(sw4.seconds), m4.elapsed % 60);
    endtask

    task automatic cyc(input bit st, input bit sp, input bit rs);
        sw1.start = st; sw1.stop = sp; sw1.reset = rs;
        sw4.start = st; sw4.stop = sp; sw4.reset = rs;
        @(posedge clk);
        m1 = step(m1, st, sp, rs, 1);
        m4 = step(m4, st, sp, rs, 4);
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        sw1.start = 1'b0; sw1.stop = 1'b0; sw1.reset = 1'b0;
        sw4.start = 1'b0; sw4.stop = 1'b0; sw4.reset = 1'b0;
        m1 = mdl_clear();
        m4 = mdl_clear();

        #12;
        compare_all();
        #8 rst_n = 1'b1;
        @(posedge clk);
        #1;

        cyc(1'b0, 1'b0, 1'b1);
        idle(5);
        check("idle.no_count", int'(sw1.seconds), 0);

        cyc(1'b1, 1'b0, 1'b0);
        check("start.status", int'(sw1.status), 1);
        idle(1);
        check("first.tick", int'(sw1.seconds), 1);
        idle(59);
        check("minute.min", int'(sw1.minutes), 1);
        check("minute.sec", int'(sw1.seconds), 0);

        idle(10);
        cyc(1'b0, 1'b1, 1'b0);
        check("stop.status", int'(sw1.status), 2);
        check("stop.sec", int'(sw1.seconds), 10);
        idle(10);
        check("hold.sec", int'(sw1.seconds), 10);
        cyc(1'b1, 1'b0, 1'b0);
        idle(1);
        check("resume.sec", int'(sw1.seconds), 11);

        cyc(1'b1, 1'b0, 1'b1);
        check("rst_start.status", int'(sw1.status), 0);
        cyc(1'b1, 1'b0, 1'b0);
        idle(3);
        cyc(1'b1, 1'b1, 1'b0);
        check("stop_start.status", int'(sw1.status), 2);

        // mid-prescale pause on the divide-by-4 instance
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0);
        idle(2);
        cyc(1'b0, 1'b1, 1'b0);
        idle(3);
        cyc(1'b1, 1'b0, 1'b0);
        idle(1);
        check("div4.pre_hold", int'(sw4.seconds), 0);
        idle(1);
        check("div4.resume_tick", int'(sw4.seconds), 1);
        idle(7);

        // asynchronous reset between clock edges
        #2 rst_n = 1'b0;
        #1;
        m1 = mdl_clear();
        m4 = mdl_clear();
        compare_all();
        #2 rst_n = 1'b1;

        cyc(1'b1, 1'b0, 1'b0);
        idle(LIMIT - 1);
        check("max.min", int'(sw1.minutes), MAX_MIN);
        check("max.sec", int'(sw1.seconds), 59);
        idle(1);
`ifdef STOPWATCH_SATURATE_EN
        check("sat.min", int'(sw1.minutes), MAX_MIN);
        check("sat.status", int'(sw1.status), 2);
`else
        check("wrap.min", int'(sw1.minutes), 0);
        check("wrap.status", int'(sw1.status), 1);
`endif
        idle(3);

        for (int i = 0; i < 600; i++) begin
            cyc($urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 39) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
